mem_port_arbiter: RTL and testbench
===================================

// Module: mem_port_arbiter
// PURPOSE
//  Two-requester arbiter sharing the single RAM port between the instruction-cache controller (req 0)
//  and the data-cache controller (req 1). Grants one transaction at a time, round-robin on contention.
//  Latches address/data/op at grant and holds the RAM command until the memory responds.
//  Returns read data with a one-cycle ready pulse. A watchdog aborts hung memory transactions.
// PARAMETERS
//  ADDR_W     32   address width
//  DATA_W     32   data width
//  TIMEOUT    255  max BUSY cycles before abort (>=1); counter width = $clog2(TIMEOUT+1)
// PORTS
//  iCLK          in   1       clock, all logic on posedge
//  iRST          in   1       synchronous reset, active-high
//  req0_read     in   1       icache read request (level, held until req0_ready)
//  req0_write    in   1       icache write request
//  req0_addr     in   ADDR_W  icache address
//  req0_wdata    in   DATA_W  icache write data
//  req0_rdata    out  DATA_W  read data to icache, valid while req0_ready=1
//  req0_ready    out  1       1-cycle completion pulse to icache
//  req1_*        --   --      identical set for dcache (req1_read/write/addr/wdata/rdata/ready)
//  req_err       out  1       1-cycle pulse with readyX when the transaction timed out
//  mem_addr      out  ADDR_W  RAM address
//  mem_wdata     out  DATA_W  RAM write data
//  mem_MemRead   out  1       RAM read command, held for whole BUSY
//  mem_MemWrite  out  1       RAM write command, held for whole BUSY
//  mem_rdata     in   DATA_W  RAM read data, valid with mem_ready
//  mem_ready     in   1       RAM completion, sampled only in BUSY
// BEHAVIOUR
//  All outputs registered. Reset: state=IDLE, rr_ptr=0 (req0 favoured first), all outputs 0, timer 0.
//  reqX active = reqX_read | reqX_write; both set -> treated as write.
//  States:
//   IDLE: no active req -> stay. One active -> grant it. Both -> grant rr_ptr's side.
//         On grant: latch addr/wdata/op, owner; next cycle BUSY with mem_addr/mem_wdata and
//         exactly one of mem_MemRead/mem_MemWrite = 1; timer cleared.
//   BUSY: commands held constant; input req changes ignored (txn completes regardless).
//         mem_ready=1 -> latch mem_rdata (reads only; writes return 0), deassert commands -> DONE.
//         timer==TIMEOUT-1 with no mem_ready -> deassert commands, rdata=0 -> DONE with err.
//         else timer+1 (saturating; never wraps).
//   DONE: one cycle; owner's readyX=1, rdataX valid, req_err=1 on abort; other side's ready=0.
//         rr_ptr <= ~owner. All requests ignored in DONE -> IDLE.
//  Latency: request seen at edge N in IDLE -> mem cmd visible cycle N+1; mem_ready at cycle M ->
//   readyX high cycle M+1; earliest next cmd at M+3 (requester may drop/change req in M+2).
//  mem_ready in IDLE/DONE ignored. Simultaneous mem_ready and timeout in same cycle: success wins.
//  Non-owner's rdata/ready stay 0 throughout. Fairness: under continuous contention grants alternate.
//  Reset mid-transaction: commands drop next cycle, no ready pulse, state IDLE, rr_ptr=0.
// TESTING
//  T1 req0_read addr=0x40, mem_ready after 3 cycles, mem_rdata=0xDEADBEEF -> mem_MemRead 3 cycles,
//     req0_ready 1 cycle with 0xDEADBEEF, req1_ready stays 0.
//  T2 req0_read and req1_write (addr 0x80, data 0x1234) same cycle after reset -> req0 served first,
//     then req1: mem_MemWrite, mem_addr=0x80, mem_wdata=0x1234; repeat both -> req0 first again
//     only after req1 (alternation 0,1,0,1 over 4 txns).
//  T3 req1_write held 1 cycle past ready -> no second grant; exactly one mem_MemWrite burst.
//  T4 TIMEOUT=8, mem_ready never -> commands high 8 cycles, then req0_ready=1, req_err=1, rdata=0.
//  T5 iRST asserted during BUSY -> next cycle mem_MemRead=0, no ready pulse; fresh request after
//     reset is granted normally.
//  T6 req0_read and req0_write both set -> mem_MemWrite only; mem_ready pulse in IDLE -> no effect.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - two-requester round-robin arbiter for a single RAM port with a watchdog
module mem_port_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic              iCLK,
    input  logic              iRST,
    input  logic              req0_read,
    input  logic              req0_write,
    input  logic [ADDR_W-1:0] req0_addr,
    input  logic [DATA_W-1:0] req0_wdata,
    output logic [DATA_W-1:0] req0_rdata,
    output logic              req0_ready,
    input  logic              req1_read,
    input  logic              req1_write,
    input  logic [ADDR_W-1:0] req1_addr,
    input  logic [DATA_W-1:0] req1_wdata,
    output logic [DATA_W-1:0] req1_rdata,
    output logic              req1_ready,
    output logic              req_err,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_MemRead,
    output logic              mem_MemWrite,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ready
);
    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t            state;
    logic              rr_ptr;
    logic              owner;
    logic              is_write;
    logic [TW-1:0]     timer;
    logic              act0;
    logic              act1;
    logic              pick1;
    logic              grant_write;
    logic [DATA_W-1:0] resp_data;

    // A requester asserting both read and write is treated as a writer.
    always_comb begin
        act0        = req0_read | req0_write;
        act1        = req1_read | req1_write;
        pick1       = act1 & (~act0 | rr_ptr);
        grant_write = pick1 ? req1_write : req0_write;
        resp_data   = is_write ? '0 : mem_rdata;
    end

    always_ff @(posedge iCLK) begin
        if (iRST) begin
            state        <= IDLE;
            rr_ptr       <= 1'b0;
            owner        <= 1'b0;
            is_write     <= 1'b0;
            timer        <= '0;
            req0_rdata   <= '0;
            req0_ready   <= 1'b0;
            req1_rdata   <= '0;
            req1_ready   <= 1'b0;
            req_err      <= 1'b0;
            mem_addr     <= '0;
            mem_wdata    <= '0;
            mem_MemRead  <= 1'b0;
            mem_MemWrite <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (act0 | act1) begin
                        owner        <= pick1;
                        is_write     <= grant_write;
                        mem_addr     <= pick1 ? req1_addr : req0_addr;
                        mem_wdata    <= pick1 ? req1_wdata : req0_wdata;
                        mem_MemWrite <= grant_write;
                        mem_MemRead  <= ~grant_write;
                        timer        <= '0;
                        state        <= BUSY;
                    end
                end
                BUSY: begin
                    // A response arriving on the last allowed cycle still counts as success.
                    if (mem_ready || timer == TW'(TIMEOUT - 1)) begin
                        mem_MemRead  <= 1'b0;
                        mem_MemWrite <= 1'b0;
                        req_err      <= ~mem_ready;
                        rr_ptr       <= ~owner;
                        state        <= DONE;
                        if (owner) begin
                            req1_ready <= 1'b1;
                            req1_rdata <= mem_ready ? resp_data : '0;
                        end else begin
                            req0_ready <= 1'b1;
                            req0_rdata <= mem_ready ? resp_data : '0;
                        end
                    end else if (timer != {TW{1'b1}}) begin
                        timer <= timer + 1'b1;
                    end
                end
                DONE: begin
                    req0_ready <= 1'b0;
                    req1_ready <= 1'b0;
                    req0_rdata <= '0;
                    req1_rdata <= '0;
                    req_err    <= 1'b0;
                    state      <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - directed self-checking bench for mem_port_arbiter
module tb_mem_port_arbiter;
    logic        iCLK = 1'b0;
    logic        iRST = 1'b1;
    logic        req0_read = 0, req0_write = 0, req1_read = 0, req1_write = 0;
    logic [31:0] req0_addr = 0, req0_wdata = 0, req1_addr = 0, req1_wdata = 0;
    logic [31:0] req0_rdata, req1_rdata, mem_addr, mem_wdata;
    logic        req0_ready, req1_ready, req_err, mem_MemRead, mem_MemWrite;
    logic [31:0] mem_rdata = 0;
    logic        mem_ready = 0;

    int total = 0;
    int bad   = 0;

    always #5 iCLK = ~iCLK;

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(8)) dut (
        .iCLK(iCLK), .iRST(iRST),
        .req0_read(req0_read), .req0_write(req0_write), .req0_addr(req0_addr),
        .req0_wdata(req0_wdata), .req0_rdata(req0_rdata), .req0_ready(req0_ready),
        .req1_read(req1_read), .req1_write(req1_write), .req1_addr(req1_addr),
        .req1_wdata(req1_wdata), .req1_rdata(req1_rdata), .req1_ready(req1_ready),
        .req_err(req_err), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_MemRead(mem_MemRead), .mem_MemWrite(mem_MemWrite),
        .mem_rdata(mem_rdata), .mem_ready(mem_ready)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Entered at the negedge of the cycle the request is presented; returns at the DONE-cycle negedge.
    task automatic serve(input int lat, input logic [31:0] rd, output int ncmd,
                         output logic rd_c, output logic wr_c,
                         output logic [31:0] a, output logic [31:0] wd);
        ncmd = 0;
        @(negedge iCLK);
        rd_c = mem_MemRead; wr_c = mem_MemWrite; a = mem_addr; wd = mem_wdata;
        for (int i = 1; i <= lat; i++) begin
            if (i > 1) @(negedge iCLK);
            if (mem_MemRead | mem_MemWrite) ncmd++;
            if (i == lat) begin
                mem_ready = 1'b1;
                mem_rdata = rd;
            end
        end
        @(negedge iCLK);
        mem_ready = 1'b0;
        mem_rdata = '0;
    endtask

    task automatic do_reset();
        iRST = 1'b1;
        @(negedge iCLK);
        @(negedge iCLK);
        iRST = 1'b0;
    endtask

    int          n, acc;
    logic        rc, wc, got;
    logic [31:0] a, wd;

    initial begin
        do_reset();
        chk("rst_outs", {req0_ready, req1_ready, req_err, mem_MemRead, mem_MemWrite}, 0);
        chk("rst_addr", mem_addr | req0_rdata | req1_rdata, 0);

        // T1 single read, three-cycle memory latency
        req0_read = 1; req0_addr = 32'h40;
        serve(3, 32'hDEADBEEF, n, rc, wc, a, wd);
        chk("t1_read_cmd", {rc, wc}, 2'b10);
        chk("t1_addr", a, 32'h40);
        chk("t1_cmd_cycles", n, 3);
        chk("t1_ready0", req0_ready, 1);
        chk("t1_rdata0", req0_rdata, 32'hDEADBEEF);
        chk("t1_ready1", req1_ready, 0);
        chk("t1_cmd_off", mem_MemRead, 0);
        req0_read = 0;
        @(negedge iCLK);
        chk("t1_ready_pulse", req0_ready, 0);

        // T2 continuous contention alternates 0,1,0,1 starting from req0
        do_reset();
        req0_read = 1; req0_addr = 32'h10;
        req1_write = 1; req1_addr = 32'h80; req1_wdata = 32'h1234;
        for (int k = 0; k < 4; k++) begin
            if (k > 0) @(negedge iCLK);
            serve(1, 32'h100 + k, n, rc, wc, a, wd);
            if (k % 2 == 0) begin
                chk("t2_owner0_cmd", {rc, wc}, 2'b10);
                chk("t2_owner0_addr", a, 32'h10);
                chk("t2_rdy", {req0_ready, req1_ready}, 2'b10);
                chk("t2_rdata0", req0_rdata, 32'h100 + k);
            end else begin
                chk("t2_owner1_cmd", {rc, wc}, 2'b01);
                chk("t2_owner1_addr", a, 32'h80);
                chk("t2_owner1_wdata", wd, 32'h1234);
                chk("t2_rdy", {req0_ready, req1_ready}, 2'b01);
                chk("t2_rdata1_write", req1_rdata, 0);
            end
        end
        req0_read = 0; req1_write = 0;

        // T3 request held through the ready cycle is not granted twice
        @(negedge iCLK);
        req1_write = 1; req1_addr = 32'h84; req1_wdata = 32'h5678;
        serve(2, 32'h0, n, rc, wc, a, wd);
        chk("t3_write", {rc, wc}, 2'b01);
        chk("t3_ready1", req1_ready, 1);
        @(negedge iCLK);
        req1_write = 0;
        acc = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge iCLK);
            acc += int'(mem_MemWrite | mem_MemRead);
        end
        chk("t3_no_regrant", acc, 0);

        // T4 watchdog abort after TIMEOUT cycles
        req0_read = 1; req0_addr = 32'h44;
        n = 0; got = 0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge iCLK);
            if (req0_ready) got = 1;
            else if (mem_MemRead) n++;
        end
        chk("t4_ready_seen", got, 1);
        chk("t4_cmd_cycles", n, 8);
        chk("t4_err", req_err, 1);
        chk("t4_rdata0", req0_rdata, 0);
        req0_read = 0;

        // response on the last allowed cycle wins over the timeout
        @(negedge iCLK);
        req0_read = 1; req0_addr = 32'h48;
        serve(8, 32'hCAFEF00D, n, rc, wc, a, wd);
        chk("t4b_cmd_cycles", n, 8);
        chk("t4b_ready_err", {req0_ready, req_err}, 2'b10);
        chk("t4b_rdata0", req0_rdata, 32'hCAFEF00D);
        req0_read = 0;

        // T5 reset in the middle of a transaction
        @(negedge iCLK);
        req0_read = 1; req0_addr = 32'h50;
        @(negedge iCLK);
        chk("t5_busy", mem_MemRead, 1);
        @(negedge iCLK);
        iRST = 1;
        @(negedge iCLK);
        chk("t5_cmd_drop", {mem_MemRead, req0_ready, req_err}, 0);
        iRST = 0; req0_read = 0;
        acc = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge iCLK);
            acc += int'(req0_ready | req1_ready | mem_MemRead | mem_MemWrite);
        end
        chk("t5_quiet", acc, 0);
        req1_read = 1; req1_addr = 32'h90;
        serve(1, 32'hA5A5A5A5, n, rc, wc, a, wd);
        chk("t5_fresh_cmd", {rc, wc}, 2'b10);
        chk("t5_fresh_addr", a, 32'h90);
        chk("t5_fresh_rdy", {req0_ready, req1_ready}, 2'b01);
        chk("t5_fresh_rdata1", req1_rdata, 32'hA5A5A5A5);
        req1_read = 0;

        // T6 stray mem_ready in IDLE, then read+write treated as write
        @(negedge iCLK);
        mem_ready = 1; mem_rdata = 32'hFFFF;
        @(negedge iCLK);
        mem_ready = 0; mem_rdata = 0;
        chk("t6_idle_ready", {req0_ready, req1_ready, req_err, mem_MemRead, mem_MemWrite}, 0);
        req0_read = 1; req0_write = 1; req0_addr = 32'h20; req0_wdata = 32'h99;
        serve(2, 32'h77, n, rc, wc, a, wd);
        chk("t6_write_only", {rc, wc}, 2'b01);
        chk("t6_wdata", wd, 32'h99);
        chk("t6_ready0", req0_ready, 1);
        chk("t6_rdata0_zero", req0_rdata, 0);
        req0_read = 0; req0_write = 0;
        @(negedge iCLK);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
